// File: rtl/change_disp_pkg.sv
// change_disp_pkg: shared FSM states, coin codes, coin weights and tally width for change_dispenser
package change_disp_pkg;
  localparam int DISP_W = 16;
  typedef enum logic [1:0] {IDLE, PULSE, WAIT, FAULT} state_t;
  typedef enum logic [1:0] {COIN_50 = 2'd0, COIN_100 = 2'd1, COIN_500 = 2'd2, COIN_1000 = 2'd3} coin_t;
  localparam logic [DISP_W-1:0] WT_50   = 16'd1;
  localparam logic [DISP_W-1:0] WT_100  = 16'd2;
  localparam logic [DISP_W-1:0] WT_500  = 16'd10;
  localparam logic [DISP_W-1:0] WT_1000 = 16'd20;
  function automatic logic [DISP_W-1:0] coin_weight(input coin_t c);
    return c == COIN_1000 ? WT_1000 : c == COIN_500 ? WT_500 : c == COIN_100 ? WT_100 : WT_50;
  endfunction
endpackage

// File: rtl/change_dispenser_coin_fifo.sv
// coin_fifo: DEPTH-entry queue of 2-bit coin codes
//   clk, rst     clock, asynchronous active-high reset
//   push, din    enqueue request and code (dropped when full, even with a simultaneous pop)
//   pop, dout    dequeue request and head code
//   full, empty  occupancy flags
module coin_fifo
  import change_disp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  coin_t din,
  input  logic  pop,
  output coin_t dout,
  output logic  full,
  output logic  empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr, rd;
  coin_t mem [DEPTH];
  logic push_ok, pop_ok;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign full    = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign empty   = wr == rd;
  assign dout    = mem[rd[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push_ok) wr <= wr + 1'b1;
      if (pop_ok) rd <= rd + 1'b1;
    end
  always_ff @(posedge clk)
    if (push_ok) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: queues change requests and drives a coin hopper one coin at a time
//   CLK, RST                      clock, asynchronous active-high reset
//   Return50/100/500/1000         one-cycle change-request pulses
//   HopperAck                     hopper ejected one coin (honoured only in WAIT)
//   FaultClr                      operator clears a hopper fault
//   Eject[3:0]                    one-hot hopper command (50/100/500/1000)
//   Busy, Fault, DropErr          status; DropErr is sticky until RST
//   Dispensed[15:0]               saturating dispensed total in 50-won units
// Build option: CHANGE_DISP_TALLY_EN builds the Dispensed accumulator; otherwise Dispensed is 0.
module change_dispenser
  import change_disp_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Return50,
  input  logic              Return100,
  input  logic              Return500,
  input  logic              Return1000,
  input  logic              HopperAck,
  input  logic              FaultClr,
  output logic [3:0]        Eject,
  output logic              Busy,
  output logic              Fault,
  output logic              DropErr,
  output logic [DISP_W-1:0] Dispensed
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t state, state_n;
  coin_t push_code, head, code;
  logic [3:0] req;
  logic [TW-1:0] timer;
  logic any, multi, full, empty, pop, ack, timeout;
  assign req       = {Return1000, Return500, Return100, Return50};
  assign any       = |req;
  // more than one bit set: clearing the lowest set bit leaves something behind
  assign multi     = |(req & (req - 4'd1));
  assign push_code = req[3] ? COIN_1000 : req[2] ? COIN_500 : req[1] ? COIN_100 : COIN_50;
  assign pop       = state == IDLE && !empty;
  assign ack       = state == WAIT && HopperAck;
  assign timeout   = timer == TW'(TIMEOUT_CYC - 1);
  coin_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (CLK),
    .rst  (RST),
    .push (any),
    .din  (push_code),
    .pop  (pop),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  state_n = empty ? IDLE : PULSE;
      PULSE: state_n = WAIT;
      WAIT:  state_n = HopperAck ? IDLE : timeout ? FAULT : WAIT;
      FAULT: state_n = FaultClr ? IDLE : FAULT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      code    <= COIN_50;
      timer   <= '0;
      DropErr <= 1'b0;
    end else begin
      if (pop) code <= head;
      timer <= state == PULSE ? '0 : state == WAIT ? timer + 1'b1 : timer;
      if (multi || (any && full)) DropErr <= 1'b1;
    end
  assign Eject = state == PULSE ? 4'b0001 << code : 4'b0000;
  assign Busy  = !empty || state != IDLE;
  assign Fault = state == FAULT;
`ifdef CHANGE_DISP_TALLY_EN
  logic [DISP_W:0] sum;
  assign sum = {1'b0, Dispensed} + {1'b0, coin_weight(code)};
  always_ff @(posedge CLK or posedge RST)
    if (RST) Dispensed <= '0;
    else if (ack) Dispensed <= sum[DISP_W] ? '1 : sum[DISP_W-1:0];
`else
  assign Dispensed = '0;
`endif
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed self-checking bench for change_dispenser
module tb_change_dispenser;
  import change_disp_pkg::*;
`ifdef CHANGE_DISP_TALLY_EN
  localparam bit TALLY = 1'b1;
`else
  localparam bit TALLY = 1'b0;
`endif
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] ret = '0;
  logic ack = 1'b0;
  logic clr = 1'b0;
  logic [3:0] eject;
  logic busy, fault, drop_err;
  logic [15:0] dispensed;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  change_dispenser #(.FIFO_DEPTH(8), .TIMEOUT_CYC(TO)) dut (
    .CLK       (clk),
    .RST       (rst),
    .Return50  (ret[0]),
    .Return100 (ret[1]),
    .Return500 (ret[2]),
    .Return1000(ret[3]),
    .HopperAck (ack),
    .FaultClr  (clr),
    .Eject     (eject),
    .Busy      (busy),
    .Fault     (fault),
    .DropErr   (drop_err),
    .Dispensed (dispensed)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] disp(input logic [15:0] v);
    return TALLY ? v : 16'd0;
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ret = '0;
    ack = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic serve(input string tag, input logic [3:0] exp);
    int n = 0;
    while (eject == 4'b0000 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, {28'd0, eject}, {28'd0, exp});
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask
  initial begin
    logic seen;
    do_reset();
    check("rst_eject", {28'd0, eject}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_drop", {31'd0, drop_err}, 32'd0);
    check("rst_disp", {16'd0, dispensed}, 32'd0);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ack_idle_ignored", {16'd0, dispensed}, 32'd0);
    ret = 4'b0010;
    @(negedge clk);
    ret = '0;
    check("lat_n1_eject", {28'd0, eject}, 32'd0);
    check("lat_n1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("lat_n2_eject", {28'd0, eject}, 32'h2);
    @(negedge clk);
    check("lat_n3_eject", {28'd0, eject}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("single_busy", {31'd0, busy}, 32'd0);
    check("single_disp", {16'd0, dispensed}, {16'd0, disp(16'd2)});
    do_reset();
    ret = 4'b1000;
    @(negedge clk);
    ret = 4'b0100;
    @(negedge clk);
    check("seq_first", {28'd0, eject}, 32'h8);
    ret = 4'b0001;
    @(negedge clk);
    ret = '0;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    serve("seq_second", 4'b0100);
    serve("seq_third", 4'b0001);
    check("seq_disp", {16'd0, dispensed}, {16'd0, disp(16'd31)});
    check("seq_busy", {31'd0, busy}, 32'd0);
    check("seq_nodrop", {31'd0, drop_err}, 32'd0);
    do_reset();
    ret = 4'b0101;
    @(negedge clk);
    ret = '0;
    check("multi_drop", {31'd0, drop_err}, 32'd1);
    serve("multi_eject", 4'b0100);
    repeat (3) @(negedge clk);
    check("multi_single", {31'd0, busy}, 32'd0);
    check("multi_disp", {16'd0, dispensed}, {16'd0, disp(16'd10)});
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i == 2) check("fill_eject", {28'd0, eject}, 32'h1);
      ret = 4'b0001;
      @(negedge clk);
    end
    check("fill_nodrop", {31'd0, drop_err}, 32'd0);
    @(negedge clk);
    ret = '0;
    check("full_drop", {31'd0, drop_err}, 32'd1);
    repeat (4) @(negedge clk);
    check("drop_sticky", {31'd0, drop_err}, 32'd1);
    do_reset();
    ret = 4'b0010;
    @(negedge clk);
    ret = 4'b0100;
    @(negedge clk);
    ret = '0;
    check("to_eject", {28'd0, eject}, 32'h2);
    repeat (TO) @(negedge clk);
    check("to_not_yet", {31'd0, fault}, 32'd0);
    @(negedge clk);
    check("to_fault", {31'd0, fault}, 32'd1);
    check("to_busy", {31'd0, busy}, 32'd1);
    ack = 1'b1;
    repeat (2) @(negedge clk);
    ack = 1'b0;
    check("fault_ack_ignored", {31'd0, fault}, 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_fault", {31'd0, fault}, 32'd0);
    serve("clr_next", 4'b0100);
    check("fault_disp", {16'd0, dispensed}, {16'd0, disp(16'd10)});
    do_reset();
    ret = 4'b0001;
    @(negedge clk);
    ret = '0;
    @(negedge clk);
    repeat (TO) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("tie_fault", {31'd0, fault}, 32'd0);
    check("tie_busy", {31'd0, busy}, 32'd0);
    check("tie_disp", {16'd0, dispensed}, {16'd0, disp(16'd1)});
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ret = 4'b0001;
      @(negedge clk);
    end
    ret = '0;
    rst = 1'b1;
    #1;
    check("arst_eject", {28'd0, eject}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_fault", {31'd0, fault}, 32'd0);
    check("arst_disp", {16'd0, dispensed}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (eject != 4'b0000 || busy) seen = 1'b1;
    end
    check("arst_no_eject", {31'd0, seen}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, sets the number of queued change coins; it SHALL be a power of two and at least 2.
REQ-002 Parameter TIMEOUT_CYC, default 1000, sets the WAIT-state cycles before a hopper fault.
REQ-003 CLK  input  1  the single clock; all state updates on rising edge.
REQ-004 RST  input  1  asynchronous active-high reset.
REQ-005 Return50 / Return100 / Return500 / Return1000  input  1 each  one-cycle change-request pulses from the control unit.
REQ-006 HopperAck  input  1  the hopper confirms that one coin was ejected.
REQ-007 FaultClr  input  1  the operator clears a hopper fault.
REQ-008 Eject  output  4  one-hot hopper command; bit0=50, bit1=100, bit2=500, bit3=1000.
REQ-009 Busy  output  1  high when the FIFO is non-empty or the FSM is not in IDLE.
REQ-010 Fault  output  1  high while the FSM is in FAULT.
REQ-011 DropErr  output  1  sticky flag for a lost change request.
REQ-012 Dispensed  output  16  running total of dispensed value in units of 50 won.

Function
REQ-013 Each Return pulse SHALL push one 2-bit denomination code (0=50, 1=100, 2=500, 3=1000) into the FIFO in the same cycle.
REQ-014 If more than one Return input is high in a cycle, only the highest denomination SHALL be pushed, and DropErr SHALL set.
REQ-015 A push while the FIFO is full SHALL be discarded and SHALL set DropErr, even if a pop occurs in the same cycle.
REQ-016 DropErr SHALL clear only on RST.
REQ-017 The FSM SHALL have the states IDLE, PULSE, WAIT and FAULT.
REQ-018 IDLE: when the FIFO is non-empty, pop the head code into a register and go to PULSE.
REQ-019 PULSE: drive Eject[code]=1 for exactly one cycle, clear the timer, and go to WAIT.
REQ-020 WAIT: Eject=0 and the timer increments each cycle.
REQ-021 WAIT: HopperAck=1 returns the FSM to IDLE and adds the coin weight (1, 2, 10 or 20) to Dispensed.
REQ-022 WAIT: if the timer reaches TIMEOUT_CYC-1 with no ack, the FSM goes to FAULT.
REQ-023 If HopperAck and the timeout occur in the same cycle, the ack SHALL win.
REQ-024 HopperAck SHALL be ignored outside WAIT.
REQ-025 FAULT: Fault=1, the in-flight coin is abandoned, the FIFO keeps accepting pushes, and FaultClr=1 returns the FSM to IDLE on the next edge.
REQ-026 Latency: a Return pulse in cycle N, with the FSM idle and the FIFO empty, SHALL produce Eject in cycle N+2.
REQ-027 Back-to-back coins: the next Eject occurs 2 cycles after the ack.
REQ-028 Dispensed SHALL saturate at 16'hFFFF and never wrap.

Reset
REQ-029 RST SHALL asynchronously force: FSM=IDLE, FIFO empty, timer=0, Eject=0, Busy=0, Fault=0, DropErr=0, Dispensed=0.
REQ-030 Reset mid-operation SHALL discard all queued and in-flight coins without issuing any further Eject pulse.

Configuration
REQ-031 Macro CHANGE_DISP_TALLY_EN defined: the Dispensed accumulator is built as specified above.
REQ-032 Macro CHANGE_DISP_TALLY_EN undefined: no accumulator logic is built, Dispensed is tied to 0, and all other behaviour is unchanged.

Structure
REQ-033 Shared package change_disp_pkg SHALL hold the FSM state encoding, the denomination codes 0-3, the weight constants 1/2/10/20, and the width constant 16.
REQ-034 The FIFO SHALL be a separate sub-module coin_fifo (parameterised depth, 2-bit data, push/pop/full/empty), instantiated once.

Verification
REQ-035 Return100 in cycle 5 with the hopper acking 3 cycles after Eject -> Eject=4'b0010 in cycle 7 only, Dispensed=2, Busy low after the ack.
REQ-036 Return1000, Return500 and Return50 in consecutive cycles -> Ejects issued in the order 1000, 500, 50, Dispensed=31.
REQ-037 Nine pulses with no ack and FIFO_DEPTH=8 -> the first coin goes in flight, 8 are queued, the ninth... (FIFO holds 8 after the first pop) no drop occurs; a tenth pulse while full sets DropErr=1.
REQ-038 Return50 and Return500 in the same cycle -> only 500 is ejected, DropErr=1.
REQ-039 No ack for TIMEOUT_CYC cycles -> Fault=1; FaultClr -> the next queued coin is ejected and Dispensed excludes the faulted coin.
REQ-040 RST asserted in WAIT with 3 coins queued -> outputs are at reset values immediately and no Eject follows.
